// File: rtl/usb_crc_engine.sv
// USB CRC5/CRC16 generator and checker: absorbs LSB-first beats, supports partial last beats.
// Optional residual comparator is built when USB_CRC_RESIDUAL_CHECK_EN is defined.
module usb_crc_engine #(
   parameter int                CRC_W    = 5,
   parameter int                DATA_W   = 8,
   parameter logic [CRC_W-1:0]  POLY     = 5'b00101,
   parameter logic [CRC_W-1:0]  RESIDUAL = 5'b01100
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         init,
   input  logic                         data_valid,
   input  logic [DATA_W-1:0]            data_in,
   input  logic                         last,
   input  logic [$clog2(DATA_W+1)-1:0]  nbits,
   output logic [CRC_W-1:0]             crc_out,
   output logic [CRC_W-1:0]             crc_tx,
   output logic                         crc_done,
   output logic                         residual_ok,
   output logic                         seq_err,
   output logic [15:0]                  bit_count
);

   localparam int NB_W = $clog2(DATA_W+1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state_reg;
   logic [CRC_W-1:0]  crc_reg;
   logic [15:0]       bit_count_reg;
   logic              crc_done_reg;
   logic              seq_err_reg;

   logic              beat_accept;
   logic [NB_W-1:0]   used_bits;
   logic [CRC_W-1:0]  crc_base;
   logic [CRC_W-1:0]  crc_next;
   logic [15:0]       count_base;
   logic [16:0]       count_sum;
   logic [15:0]       count_next;
   logic [DATA_W-1:0] bit_en;
   logic [CRC_W-1:0]  stage [0:DATA_W];

   // A beat coincident with init is always taken, whatever the state.
   assign beat_accept = data_valid & (init | (state_reg == ACCUM));

   always_comb begin
      used_bits = NB_W'(DATA_W);
      if (last) begin
         used_bits = (nbits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : nbits;
      end
   end

   assign crc_base = init ? {CRC_W{1'b1}} : crc_reg;
   assign stage[0] = crc_base;

   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
         logic fb;
         assign bit_en[gi] = (gi < int'(used_bits));
         assign fb = data_in[gi] ^ stage[gi][CRC_W-1];
         assign stage[gi+1] = bit_en[gi]
                              ? ({stage[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}}))
                              : stage[gi];
      end
   endgenerate

   assign crc_next = stage[DATA_W];

   assign count_base = init ? 16'd0 : bit_count_reg;
   assign count_sum  = {1'b0, count_base} + 17'(used_bits);
   assign count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];

`ifdef USB_CRC_RESIDUAL_CHECK_EN
   logic residual_ok_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         residual_ok_reg <= 1'b0;
      end else if (beat_accept && last) begin
         residual_ok_reg <= (crc_next == RESIDUAL);
      end else if (init) begin
         residual_ok_reg <= 1'b0;
      end
   end

   assign residual_ok = residual_ok_reg;
`else
   assign residual_ok = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         crc_reg       <= {CRC_W{1'b1}};
         bit_count_reg <= 16'd0;
         crc_done_reg  <= 1'b0;
         seq_err_reg   <= 1'b0;
      end else begin
         crc_done_reg <= 1'b0;
         if (state_reg == DONE) begin
            state_reg <= IDLE;
         end
         if (init) begin
            state_reg     <= ACCUM;
            crc_reg       <= {CRC_W{1'b1}};
            bit_count_reg <= 16'd0;
            seq_err_reg   <= 1'b0;
         end
         // Later assignments override the plain reseed when a beat rides along with init.
         if (beat_accept) begin
            crc_reg       <= crc_next;
            bit_count_reg <= count_next;
            if (last) begin
               state_reg    <= DONE;
               crc_done_reg <= 1'b1;
            end
         end else if (data_valid) begin
            seq_err_reg <= 1'b1;
         end
      end
   end

   assign crc_out   = ~crc_reg;
   assign crc_done  = crc_done_reg;
   assign seq_err   = seq_err_reg;
   assign bit_count = bit_count_reg;

   generate
      for (genvar gi = 0; gi < CRC_W; gi++) begin : g_rev
         assign crc_tx[gi] = crc_out[CRC_W-1-gi];
      end
   endgenerate

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: one CRC5 and one CRC16 instance, both with 8-bit beats.
module tb_usb_crc_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef USB_CRC_RESIDUAL_CHECK_EN
   localparam logic [31:0] RES_EXP = 32'd1;
`else
   localparam logic [31:0] RES_EXP = 32'd0;
`endif

   logic        rst5, init5, dv5, last5;
   logic [7:0]  din5;
   logic [3:0]  nb5;
   logic [4:0]  crc5_out, crc5_tx;
   logic        done5, rok5, serr5;
   logic [15:0] cnt5;

   logic        rst16, init16, dv16, last16;
   logic [7:0]  din16;
   logic [3:0]  nb16;
   logic [15:0] crc16_out, crc16_tx;
   logic        done16, rok16, serr16;
   logic [15:0] cnt16;

   usb_crc_engine #(.CRC_W(5), .DATA_W(8), .POLY(5'b00101), .RESIDUAL(5'b01100)) dut5 (
      .clk(clk), .rst(rst5), .init(init5), .data_valid(dv5), .data_in(din5),
      .last(last5), .nbits(nb5), .crc_out(crc5_out), .crc_tx(crc5_tx),
      .crc_done(done5), .residual_ok(rok5), .seq_err(serr5), .bit_count(cnt5)
   );

   usb_crc_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h8005), .RESIDUAL(16'h800D)) dut16 (
      .clk(clk), .rst(rst16), .init(init16), .data_valid(dv16), .data_in(din16),
      .last(last16), .nbits(nb16), .crc_out(crc16_out), .crc_tx(crc16_tx),
      .crc_done(done16), .residual_ok(rok16), .seq_err(serr16), .bit_count(cnt16)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst5 = 1'b1; init5 = 1'b0; dv5 = 1'b0; last5 = 1'b0; din5 = 8'h00; nb5 = 4'd0;
      rst16 = 1'b1; init16 = 1'b0; dv16 = 1'b0; last16 = 1'b0; din16 = 8'h00; nb16 = 4'd0;
      tick;
      chk("rst_crc5_out", 32'(crc5_out), 'h0);
      chk("rst_crc5_tx", 32'(crc5_tx), 'h0);
      chk("rst_done5", 32'(done5), 'h0);
      chk("rst_rok5", 32'(rok5), 'h0);
      chk("rst_serr5", 32'(serr5), 'h0);
      chk("rst_cnt5", 32'(cnt5), 'h0);
      chk("rst_crc16_out", 32'(crc16_out), 'h0);
      rst5 = 1'b0; rst16 = 1'b0;
      tick;

      // beat in IDLE without init
      dv5 = 1'b1; din5 = 8'hA5;
      tick;
      dv5 = 1'b0;
      chk("idle_seq_err", 32'(serr5), 'h1);
      chk("idle_crc_unchanged", 32'(crc5_out), 'h0);
      chk("idle_cnt_unchanged", 32'(cnt5), 'h0);
      init5 = 1'b1;
      tick;
      init5 = 1'b0;
      chk("init_clears_seq_err", 32'(serr5), 'h0);
      chk("init_crc_out", 32'(crc5_out), 'h0);

      // SETUP addr 0 endp 0: 11 zero bits
      dv5 = 1'b1; din5 = 8'h00; last5 = 1'b0;
      tick;
      chk("setup_cnt_mid", 32'(cnt5), 'd8);
      chk("setup_done_mid", 32'(done5), 'h0);
      last5 = 1'b1; nb5 = 4'd3;
      tick;
      dv5 = 1'b0; last5 = 1'b0;
      chk("setup_done", 32'(done5), 'h1);
      chk("setup_crc_out", 32'(crc5_out), 'h08);
      chk("setup_crc_tx", 32'(crc5_tx), 'h02);
      chk("setup_cnt", 32'(cnt5), 'd11);
      chk("setup_rok", 32'(rok5), 'h0);
      tick;
      chk("setup_done_pulse_end", 32'(done5), 'h0);
      chk("setup_crc_held", 32'(crc5_out), 'h08);

      // CRC5 check: 11 data bits then CRC bits 0,1,0,0,0
      init5 = 1'b1;
      tick;
      init5 = 1'b0;
      dv5 = 1'b1; din5 = 8'h00;
      tick;
      din5 = 8'h10; last5 = 1'b1; nb5 = 4'd8;
      tick;
      dv5 = 1'b0; last5 = 1'b0;
      chk("res5_done", 32'(done5), 'h1);
      chk("res5_ok", 32'(rok5), RES_EXP);
      chk("res5_crc_out", 32'(crc5_out), 'h13);
      chk("res5_cnt", 32'(cnt5), 'd16);

      // same packet with one flipped bit, started by init coincident with a beat
      init5 = 1'b1; dv5 = 1'b1; din5 = 8'h00;
      tick;
      init5 = 1'b0; din5 = 8'h11; last5 = 1'b1; nb5 = 4'd8;
      tick;
      dv5 = 1'b0; last5 = 1'b0;
      chk("res5_flip_done", 32'(done5), 'h1);
      chk("res5_flip_ok", 32'(rok5), 'h0);
      chk("res5_flip_cnt", 32'(cnt5), 'd16);

      // init + new beat during the DONE cycle
      init5 = 1'b1;
      tick;
      init5 = 1'b0;
      dv5 = 1'b1; din5 = 8'h00;
      tick;
      last5 = 1'b1; nb5 = 4'd3;
      tick;
      chk("b2b_done_a", 32'(done5), 'h1);
      init5 = 1'b1; last5 = 1'b0; din5 = 8'h00;
      tick;
      init5 = 1'b0;
      chk("b2b_done_single", 32'(done5), 'h0);
      chk("b2b_cnt_restart", 32'(cnt5), 'd8);
      last5 = 1'b1; nb5 = 4'd3;
      tick;
      dv5 = 1'b0; last5 = 1'b0;
      chk("b2b_done_b", 32'(done5), 'h1);
      chk("b2b_crc_out", 32'(crc5_out), 'h08);
      chk("b2b_cnt", 32'(cnt5), 'd11);

      // beat in DONE without init is rejected
      dv5 = 1'b1; din5 = 8'hFF;
      tick;
      dv5 = 1'b0;
      chk("done_beat_seq_err", 32'(serr5), 'h1);
      chk("done_beat_crc_held", 32'(crc5_out), 'h08);
      chk("done_beat_cnt_held", 32'(cnt5), 'd11);

      // CRC16 zero-length packet
      init16 = 1'b1;
      tick;
      init16 = 1'b0;
      dv16 = 1'b1; last16 = 1'b1; nb16 = 4'd0; din16 = 8'hFF;
      tick;
      dv16 = 1'b0; last16 = 1'b0;
      chk("zlp_done", 32'(done16), 'h1);
      chk("zlp_crc_out", 32'(crc16_out), 'h0000);
      chk("zlp_cnt", 32'(cnt16), 'd0);

      // CRC16 of a single 0x00 byte
      init16 = 1'b1; dv16 = 1'b1; din16 = 8'h00; last16 = 1'b1; nb16 = 4'd8;
      tick;
      init16 = 1'b0; dv16 = 1'b0; last16 = 1'b0;
      chk("byte0_done", 32'(done16), 'h1);
      chk("byte0_crc_out", 32'(crc16_out), 'h02FD);
      chk("byte0_crc_tx", 32'(crc16_tx), 'hBF40);
      chk("byte0_cnt", 32'(cnt16), 'd8);

      // CRC16 check: byte 0x00 followed by its CRC in wire order
      init16 = 1'b1; dv16 = 1'b1; din16 = 8'h00;
      tick;
      init16 = 1'b0; din16 = 8'h40;
      tick;
      din16 = 8'hBF; last16 = 1'b1; nb16 = 4'd8;
      tick;
      dv16 = 1'b0; last16 = 1'b0;
      chk("res16_ok", 32'(rok16), RES_EXP);
      chk("res16_crc_out", 32'(crc16_out), 'h7FF2);
      chk("res16_cnt", 32'(cnt16), 'd24);

      // rst between beats of a CRC16 packet
      init16 = 1'b1; dv16 = 1'b1; din16 = 8'h00;
      tick;
      init16 = 1'b0; din16 = 8'h55; rst16 = 1'b1;
      tick;
      rst16 = 1'b0; dv16 = 1'b0;
      chk("mid_rst_crc_out", 32'(crc16_out), 'h0);
      chk("mid_rst_crc_tx", 32'(crc16_tx), 'h0);
      chk("mid_rst_cnt", 32'(cnt16), 'd0);
      chk("mid_rst_done", 32'(done16), 'h0);
      chk("mid_rst_serr", 32'(serr16), 'h0);
      init16 = 1'b1; dv16 = 1'b1; din16 = 8'h00; last16 = 1'b1; nb16 = 4'd8;
      tick;
      init16 = 1'b0; dv16 = 1'b0; last16 = 1'b0;
      chk("post_rst_crc_out", 32'(crc16_out), 'h02FD);
      chk("post_rst_done", 32'(done16), 'h1);

      // bit_count saturation
      init16 = 1'b1;
      tick;
      init16 = 1'b0;
      dv16 = 1'b1; last16 = 1'b0;
      for (int i = 0; i < 8191; i++) begin
         din16 = 8'($urandom);
         tick;
      end
      chk("sat_below", 32'(cnt16), 'hFFF8);
      tick;
      chk("sat_reach", 32'(cnt16), 'hFFFF);
      tick;
      chk("sat_hold", 32'(cnt16), 'hFFFF);
      dv16 = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_crc_engine.md
# usb_crc_engine

Sequential, parametrised USB CRC generator/checker for the SIE. It consumes packet bits in multi-bit beats (LSB-first, USB wire order), accumulates CRC5 (tokens) or CRC16 (data packets) across a whole packet, and supports partial final beats. On completion it presents the transmit CRC in both polynomial and wire order, and a receive-side residual check. One instance serves either the TX path (generate) or the RX path (check).

## Interface
- CRC_W, 5, CRC width; legal values 5 or 16.
- DATA_W, 8, bits per input beat; legal range 1..16.
- POLY, 5'b00101 (CRC16: 16'h8005), generator without the x^CRC_W term.
- RESIDUAL, 5'b01100 (CRC16: 16'h800D), expected register value after CRC bits are fed through.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  start of packet: reload seed (all ones), enter ACCUM.
- data_valid  in  1  beat present on data_in.
- data_in  in  DATA_W  beat; data_in[0] is processed first.
- last  in  1  qualifies data_valid: final beat of the packet.
- nbits  in  $clog2(DATA_W+1)  valid bits in the last beat (0..DATA_W); ignored unless last=1; bits [nbits-1:0] are used.
- crc_out  out  CRC_W  ~crc register; MSB is the x^(CRC_W-1) coefficient.
- crc_tx  out  CRC_W  crc_out bit-reversed, for an LSB-first serializer.
- crc_done  out  1  one-cycle pulse: packet CRC complete.
- residual_ok  out  1  crc register equals RESIDUAL at crc_done; held until next init.
- seq_err  out  1  sticky: beat received outside ACCUM; cleared by init or rst.
- bit_count  out  16  bits absorbed since init; saturates at 16'hFFFF.

## Operation
- States: IDLE, ACCUM, DONE. Reset -> IDLE.
- IDLE: init -> ACCUM. data_valid without init: beat ignored, seq_err set.
- ACCUM: data_valid & !last -> absorb DATA_W bits, stay. data_valid & last -> absorb nbits bits, -> DONE. init -> reseed, stay.
- DONE: lasts exactly one cycle; crc_done=1; -> IDLE, or -> ACCUM if init is asserted in that cycle.
- Per-bit update, applied sequentially: fb = d ^ crc[CRC_W-1]; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). All used bits of one beat are folded in a single cycle (unrolled).
- nbits=0 with last: no bits absorbed; the packet still completes.
- init with data_valid in the same cycle: reseed first, then absorb the beat from the seed. It counts as the first beat of the new packet, in any state.
- bit_count adds the number of bits absorbed per beat; it is reset to 0 by init (or to that beat's bit count when init and a beat coincide).
- No backpressure: every beat in ACCUM (or coincident with init) is accepted in its cycle.

## Timing
- Reset values: crc register all ones, so crc_out=0 and crc_tx=0. crc_done=0, residual_ok=0, seq_err=0, bit_count=0, state IDLE.
- crc register and bit_count are updated at the edge that samples the beat; the new values are visible the following cycle.
- crc_done is asserted the cycle after the last beat is sampled. crc_out, crc_tx and residual_ok are valid in that cycle and held until the next init or beat.
- init latency: one cycle to reseed; crc_out reads 0 the cycle after an init without a beat.
- rst mid-packet: returns all state to reset values at that edge; the beat in that cycle is discarded.

## Configuration
- USB_CRC_RESIDUAL_CHECK_EN defined: residual comparator is built, and residual_ok is registered at the last-beat edge.
- Not defined: comparator is removed and residual_ok is tied to 0. All other behaviour is identical.

## Test plan
- CRC5, DATA_W=8: init; beat 8'h00; last beat 8'h00 with nbits=3 (SETUP addr 0, endp 0) -> crc_done one cycle later, crc_out=5'b01000, crc_tx=5'b00010, bit_count=11.
- CRC5 check: same 11 zero bits, then CRC bits 0,1,0,0,0 in wire order (16 bits total over two beats) -> residual_ok=1. Flip any one bit -> residual_ok=0.
- CRC16, DATA_W=8: init, then last with nbits=0 (zero-length DATA0) -> crc_out=16'h0000, bit_count=0, crc_done pulse.
- data_valid in IDLE without init -> seq_err=1, crc register unchanged. Next init -> seq_err=0.
- init coincident with the DONE cycle and a new beat -> crc_done pulse still seen, new packet CRC equals that from a clean init; back-to-back packets show no idle gap.
- rst asserted between beats of a CRC16 packet -> all outputs at reset values the next cycle. Packet restarted with init -> correct CRC.
